// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : drain_fifo
//  Purpose  : Show-ahead FIFO behind the shift buffer, with a registered
//             early-stall output, a fill-level output and a sticky overflow flag.
//  Revision : 1.0
// ============================================================================
module drain_fifo #(
   parameter int p_width  = 32,
   parameter int p_depth  = 8,
   parameter int p_margin = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [p_width-1:0]           in,
   input  logic                         in_valid,
   output logic                         o_stall,
   output logic [p_width-1:0]           out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(p_depth+1)-1:0] o_level,
   output logic                         o_overflow
);

   localparam int c_aw = $clog2(p_depth);
   localparam int c_pw = c_aw + 1;
   localparam int c_lw = $clog2(p_depth + 1);
   localparam logic [c_pw-1:0] c_thresh = c_pw'(p_depth - p_margin);

   logic [p_width-1:0] mem_q [p_depth];
   logic [c_pw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [c_pw-1:0]    rd_ptr_q, rd_ptr_d;
   logic               stall_q, stall_d;
   logic               ovf_q, ovf_d;

   logic               empty, full, push, pop;
   logic [c_pw-1:0]    level, level_d;

   // The extra pointer bit separates full (wrap bits differ) from empty.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]) &&
                      (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]);
   assign level     = wr_ptr_q - rd_ptr_q;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{c_aw{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{c_aw{1'b0}}, pop};
      level_d  = level + {{c_aw{1'b0}}, push} - {{c_aw{1'b0}}, pop};
      stall_d  = (level_d >= c_thresh);
      ovf_d    = ovf_q || (in_valid && full && !pop);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         stall_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         stall_q  <= stall_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage has no reset; emptiness is tracked purely by the pointers.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[c_aw-1:0]] <= in;
      end
   end

   assign out        = out_valid ? mem_q[rd_ptr_q[c_aw-1:0]] : '0;
   assign o_level    = c_lw'(level);
   assign o_stall    = stall_q;
   assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drain_fifo
//  Purpose  : Scoreboard bench for drain_fifo (default parameters).
//  Revision : 1.0
// ============================================================================
module tb_drain_fifo;

   localparam int c_depth  = 8;
   localparam int c_thresh = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        o_stall;
   logic [31:0] out_data;
   logic        out_valid;
   logic [3:0]  o_level;
   logic        o_overflow;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   int          mcount = 0;
   logic        exp_ovf = 1'b0;

   drain_fifo dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .in         (in_data),
      .in_valid   (in_valid),
      .o_stall    (o_stall),
      .out        (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .o_level    (o_level),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; the reference count decides acceptance.
   task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
      logic p_pop, p_push;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      p_pop  = (mcount > 0) && rdy;
      p_push = v && ((mcount < c_depth) || p_pop);
      if (p_push) sb.push_back(d);
      if (v && !p_push) exp_ovf = 1'b1;
      @(posedge clk);
      #1;
      mcount = mcount + int'(p_push) - int'(p_pop);
      chk("level",    32'(o_level),    32'(mcount));
      chk("valid",    32'(out_valid),  32'(mcount > 0));
      chk("stall",    32'(o_stall),    32'(mcount >= c_thresh));
      chk("overflow", 32'(o_overflow), 32'(exp_ovf));
   endtask

   initial begin
      int sent;
      int budget;
      logic stall_prev;

      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL out_unexpected: got 0x%0h expected no word at %0t", out_data, $time);
               end else begin
                  chk("out_order", out_data, sb.pop_front());
               end
            end
         end
      join_none

      // Reset and idle
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(o_level), 32'd0);
      rst = 1'b0;
      repeat (2) cycle(1'b0, 32'h0, 1'b0);
      chk("idle_stall", 32'(o_stall), 32'd0);

      // Pass-through with consumer always ready
      cycle(1'b1, 32'h1, 1'b1);
      cycle(1'b1, 32'h2, 1'b1);
      cycle(1'b1, 32'h3, 1'b1);
      repeat (2) cycle(1'b0, 32'h0, 1'b1);

      // Fill to full with consumer blocked, then overflow attempt
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0);
      cycle(1'b1, 32'hDEAD, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      // Push and pop together at full
      cycle(1'b1, 32'h100, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);
      chk("drained", 32'(sb.size()), 32'd0);

      // Asynchronous reset with five words stored
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_level", 32'(o_level), 32'd0);
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_ovf",   32'(o_overflow), 32'd0);
      sb.delete();
      mcount  = 0;
      exp_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(1'b0, 32'h0, 1'b0);

      // Wrap-around stream with throttling upstream
      sent       = 0;
      budget     = 0;
      stall_prev = 1'b0;
      while ((sent < 40 || mcount > 0) && budget < 2000) begin
         logic v;
         logic cur_stall;
         v = (sent < 40) && !stall_prev;
         cur_stall = o_stall;
         cycle(v, 32'h1000 + 32'(sent), 1'($urandom_range(0, 1)));
         if (v) sent++;
         stall_prev = cur_stall;
         budget++;
      end
      if (budget >= 2000) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout: got %0d sent expected 40 drained", sent);
      end
      chk("stream_ovf", 32'(o_overflow), 32'd0);
      chk("stream_sb", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/drain_fifo.md
Name: drain_fifo

Overview:
- Downstream consumer of the shift buffer stage. Captures its out/out_valid word stream into a small first-in first-out buffer and presents it to the next stage over a valid/ready handshake.
- Generates the registered stall that throttles the shift buffer before the FIFO fills.
- Reports fill level and a sticky overflow flag for debug and status.

Parameters:
- p_width, 32, data word width in bits.
- p_depth, 8, FIFO depth in words; must be a power of two and at least 4.
- p_margin, 2, free-slot headroom; o_stall asserts when level reaches p_depth - p_margin. Must be at least 1 and less than p_depth.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  asynchronous active-high reset.
- in  input  p_width  data word from the upstream shift buffer.
- in_valid  input  1  in carries a valid word this cycle.
- o_stall  output  1  registered stall request to upstream; drives the shift buffer i_stall.
- out  output  p_width  head-of-FIFO word, show-ahead.
- out_valid  output  1  FIFO non-empty; out is valid.
- out_ready  input  1  downstream accepts out this cycle.
- o_level  output  clog2(p_depth+1)  current number of stored words.
- o_overflow  output  1  sticky flag: a valid word was dropped.

Behaviour:
- Reset (i_rst high, asynchronous assert; release takes effect at the next clock edge):
  - Read and write pointers, level, o_stall and o_overflow all go to 0.
  - out_valid = 0; out = 0.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored words immediately.
- Storage:
  - p_depth-entry memory.
  - Read and write pointers are clog2(p_depth)+1 bits; the extra wrap bit distinguishes full from empty.
  - Pointers wrap naturally at p_depth.
- Derived signals:
  - empty = (pointers equal).
  - full = (index bits equal, wrap bits differ).
  - o_level = wr_ptr - rd_ptr, modulo 2^(clog2(p_depth)+1).
- Write (push) = in_valid and (not full, or pop in the same cycle).
  - A simultaneous push and pop at full is accepted; level is unchanged.
- Read (pop) = out_valid and out_ready.
- Output:
  - out = mem[rd_ptr index], combinational show-ahead.
  - out_valid = not empty.
  - No fall-through: a word written into an empty FIFO appears on out one cycle after the write edge.
  - While out_valid is high and out_ready is low, out is held stable.
  - When empty, out is don't-care; the bench must not check it.
- Overflow: in_valid while full with no pop in the same cycle drops the word. o_overflow is set the next cycle and stays set until reset. Pointers are unaffected.
- Stall:
  - o_stall is registered from the next level: o_stall <= (level_next >= p_depth - p_margin), where level_next = level + push - pop.
  - Upstream reacts one cycle after o_stall rises, so at least one word can still arrive after assertion. p_margin >= 1 guarantees no overflow with a compliant upstream.
  - o_stall deasserts the cycle after the level drops below the threshold.
- Simultaneous events:
  - Push and pop when empty: only the push takes effect; the pop is impossible since out_valid = 0.
  - Push and pop when non-empty: both take effect; level is unchanged.
- Level arithmetic: push and pop are 1-bit; level changes by at most ±1 per cycle and never exceeds p_depth.

Test Plan:
- Reset, then idle: out_valid=0, o_stall=0, o_level=0, o_overflow=0. Assert i_rst mid-stream with 5 words stored: o_level=0 and out_valid=0 immediately, before any clock edge.
- out_ready=1, push words 0x1,0x2,0x3 on consecutive cycles: out shows 0x1,0x2,0x3 starting one cycle after the first push; o_level never exceeds 1; o_stall stays 0.
- out_ready=0, push 6 words (defaults): o_stall rises the cycle after the 6th push; push 2 more: o_level=8 (full), out_valid=1, o_overflow=0.
- Full with out_ready=0, in_valid=1 carrying 0xDEAD: word dropped, o_overflow=1 next cycle and stays set; o_level stays 8; subsequent drain shows no 0xDEAD.
- Full, in_valid=1 and out_ready=1 in the same cycle: level stays 8, the new word is accepted and later appears last in order. Drain with out_ready=1: o_stall falls the cycle after level drops to 5.
- Wrap-around: stream 40 incrementing words with random out_ready (about 50%), upstream honouring o_stall with 1-cycle latency: all 40 words appear in order, o_overflow=0, o_level matches the scoreboard count every cycle.
